// File: rtl/is_mem_seq.sv
// Byte-memory sequencer: arbitrates 32-bit big-endian instruction fetches (4 byte reads)
// against single-byte loader writes on one single-port memory with an async read port.
module is_mem_seq #(
  parameter int ADDR_W    = 9,
  parameter int MEM_BYTES = 512
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ready,
  output logic [31:0]       if_data,
  output logic              if_err,
  input  logic              ld_req,
  input  logic [31:0]       ld_addr,
  input  logic [7:0]        ld_wdata,
  output logic              ld_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        r_cnt;
  logic [ADDR_W-1:0] r_base;
  logic [23:0]       r_asm;
  logic [31:0]       r_data;
  logic              r_err;
  logic              r_last_ld;
  logic [ADDR_W-1:0] r_ld_addr;
  logic [7:0]        r_ld_wdata;
  logic              r_ld_ok;

  logic [32:0]       w_if_end;
  logic              w_if_bad;
  logic              w_grant_if;
  logic              w_grant_ld;

  // 33-bit sum so an address near 2^32 cannot wrap into range
  assign w_if_end   = {1'b0, if_addr} + 33'd3;
  assign w_if_bad   = (if_addr[1:0] != 2'b00) || (w_if_end >= 33'(MEM_BYTES));
  assign w_grant_if = if_req && (!ld_req || r_last_ld);
  assign w_grant_ld = ld_req && !w_grant_if;

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 2'd0;
      r_base     <= '0;
      r_asm      <= '0;
      r_data     <= '0;
      r_err      <= 1'b0;
      r_last_ld  <= 1'b1;
      r_ld_addr  <= '0;
      r_ld_wdata <= '0;
      r_ld_ok    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_if) begin
            r_last_ld <= 1'b0;
            r_base    <= if_addr[ADDR_W-1:0];
            r_cnt     <= 2'd0;
            if (w_if_bad) begin
              r_data  <= '0;
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_RD;
            end
          end else if (w_grant_ld) begin
            r_last_ld  <= 1'b1;
            r_ld_addr  <= ld_addr[ADDR_W-1:0];
            r_ld_wdata <= ld_wdata;
            r_ld_ok    <= (ld_addr < 32'(MEM_BYTES));
            r_state    <= S_WR;
          end
        end
        S_RD: begin
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            r_data  <= {r_asm, mem_rdata};
            r_err   <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_asm <= {r_asm[15:0], mem_rdata};
          end
        end
        S_WR:    r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    case (r_state)
      S_RD: mem_addr = r_base + {{(ADDR_W-2){1'b0}}, r_cnt};
      S_WR: begin
        mem_addr  = r_ld_addr;
        mem_wdata = r_ld_wdata;
        // Reset gate keeps a write from landing on the edge that aborts it
        mem_we    = r_ld_ok && Reset;
      end
      default: ;
    endcase
  end

  assign if_ready = (r_state == S_DONE);
  assign ld_ack   = (r_state == S_WR);
  assign busy     = (r_state != S_IDLE);
  assign if_data  = r_data;
  assign if_err   = r_err;

endmodule

// File: tb/tb_is_mem_seq.sv
// Scoreboard bench for is_mem_seq: a byte-array reference memory predicts every
// fetch word and write in grant order; a negedge monitor checks each ready/ack.
module tb_is_mem_seq;
  localparam int ADDR_W    = 9;
  localparam int MEM_BYTES = 512;

  logic              CLK = 1'b0;
  logic              Reset = 1'b0;
  logic              if_req = 1'b0, ld_req = 1'b0;
  logic [31:0]       if_addr = '0, ld_addr = '0;
  logic [7:0]        ld_wdata = '0;
  logic              if_ready, if_err, ld_ack, mem_we, busy;
  logic [31:0]       if_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata, mem_rdata;

  is_mem_seq #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES)) dut (
    .CLK(CLK), .Reset(Reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_data(if_data), .if_err(if_err),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  // physical memory; backdoor port preloads it while the DUT is held in reset
  logic [7:0]        mem [MEM_BYTES];
  logic              bk_we = 1'b0;
  logic [ADDR_W-1:0] bk_addr = '0;
  logic [7:0]        bk_data = '0;
  assign mem_rdata = mem[mem_addr];
  always @(posedge CLK) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    else if (bk_we) mem[bk_addr] <= bk_data;
  end

  typedef struct {
    bit          ld;
    logic [31:0] data;
    bit          err;
    bit          we;
    logic [8:0]  addr;
    logic [7:0]  wd;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  ref_mem [MEM_BYTES];
  bit          last_ld = 1'b1;
  int          checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic predict_fetch(input logic [31:0] fa);
    exp_t e;
    e = '{ld: 1'b0, data: 32'h0, err: 1'b0, we: 1'b0, addr: 9'h0, wd: 8'h0};
    e.err = (fa % 4 != 0) || (longint'(fa) + 3 >= MEM_BYTES);
    if (!e.err)
      e.data = {ref_mem[fa], ref_mem[fa+1], ref_mem[fa+2], ref_mem[fa+3]};
    exp_q.push_back(e);
  endtask

  task automatic predict_load(input logic [31:0] la, input logic [7:0] lw);
    exp_t e;
    e = '{ld: 1'b1, data: 32'h0, err: 1'b0, we: 1'b0, addr: 9'h0, wd: lw};
    e.we   = (longint'(la) < MEM_BYTES);
    e.addr = la[8:0];
    if (e.we) ref_mem[la] = lw;
    exp_q.push_back(e);
  endtask

  always @(negedge CLK) begin
    if (Reset && (if_ready || ld_ack)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_response", {30'h0, if_ready, ld_ack}, 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (!e.ld) begin
          chk("resp_is_fetch", {31'h0, if_ready}, 32'h1);
          chk("if_data", if_data, e.data);
          chk("if_err", {31'h0, if_err}, {31'h0, e.err});
        end else begin
          chk("resp_is_load", {31'h0, ld_ack}, 32'h1);
          chk("ld_mem_we", {31'h0, mem_we}, {31'h0, e.we});
          chk("ld_mem_addr", {23'h0, mem_addr}, {23'h0, e.addr});
          chk("ld_mem_wdata", {24'h0, mem_wdata}, {24'h0, e.wd});
        end
      end
    end
  end

  int          t_rdy_at, t_busy_n;
  bit          t_addr_nz;
  logic [8:0]  t_addr_q[$];

  // One request round: predicts grant order, holds each req until its ready/ack.
  task automatic txn(input bit f, input bit l, input logic [31:0] fa,
                     input logic [31:0] la, input logic [7:0] lw);
    int cyc;
    if (f && l) begin
      if (last_ld) begin predict_fetch(fa); predict_load(la, lw); last_ld = 1'b1; end
      else begin predict_load(la, lw); predict_fetch(fa); last_ld = 1'b0; end
    end else if (f) begin
      predict_fetch(fa); last_ld = 1'b0;
    end else begin
      predict_load(la, lw); last_ld = 1'b1;
    end
    @(negedge CLK);
    if_req = f; if_addr = fa; ld_req = l; ld_addr = la; ld_wdata = lw;
    t_busy_n = 0; t_rdy_at = -1; t_addr_nz = 1'b0; t_addr_q.delete(); cyc = 0;
    while ((if_req || ld_req) && cyc < 100) begin
      @(negedge CLK);
      cyc++;
      if (cyc == 1 && !l) if_addr = $urandom;
      if (cyc == 1 && !f) begin ld_addr = $urandom; ld_wdata = $urandom; end
      if (busy) t_busy_n++;
      if (busy && !if_ready && !ld_ack) t_addr_q.push_back(mem_addr);
      if (mem_addr != 0 && !ld_ack) t_addr_nz = 1'b1;
      if (if_ready) begin if_req = 1'b0; t_rdy_at = cyc; end
      if (ld_ack) ld_req = 1'b0;
    end
    if (if_req || ld_req) begin
      chk("txn_timeout", {30'h0, if_req, ld_req}, 32'h0);
      if_req = 1'b0; ld_req = 1'b0;
    end
  endtask

  initial begin
    int n, cyc, kind, r;
    logic [31:0] fa, la;
    logic [7:0]  pat [4];
    pat[0] = 8'h20; pat[1] = 8'h01; pat[2] = 8'h00; pat[3] = 8'h05;

    Reset = 1'b0;
    for (int i = 0; i < MEM_BYTES; i++) begin
      @(negedge CLK);
      bk_we = 1'b1; bk_addr = ADDR_W'(i);
      bk_data = (i < 4) ? pat[i] : 8'($urandom);
      ref_mem[i] = bk_data;
    end
    @(negedge CLK);
    bk_we = 1'b0;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_if_ready", {31'h0, if_ready}, 32'h0);
    chk("rst_if_data", if_data, 32'h0);
    chk("rst_if_err", {31'h0, if_err}, 32'h0);
    chk("rst_ld_ack", {31'h0, ld_ack}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_mem_addr", {23'h0, mem_addr}, 32'h0);
    chk("rst_mem_wdata", {24'h0, mem_wdata}, 32'h0);
    Reset = 1'b1;

    // contention straight out of reset: fetch, load, fetch while both stay high
    predict_fetch(32'h10); predict_load(32'h10, 8'hAB); predict_fetch(32'h10);
    last_ld = 1'b0;
    @(negedge CLK);
    if_req = 1'b1; if_addr = 32'h10; ld_req = 1'b1; ld_addr = 32'h10; ld_wdata = 8'hAB;
    n = 0; cyc = 0;
    while (n < 3 && cyc < 60) begin
      @(negedge CLK);
      cyc++;
      if (if_ready || ld_ack) begin
        n++;
        chk("rr_order", {31'h0, ld_ack}, (n == 2) ? 32'h1 : 32'h0);
      end
    end
    chk("rr_events", n, 3);
    if_req = 1'b0; ld_req = 1'b0;

    // aligned fetch at 0: address walk, latency, busy length, word
    txn(1'b1, 1'b0, 32'h0, 32'h0, 8'h0);
    chk("f0_rdy_latency", t_rdy_at, 5);
    chk("f0_busy_cycles", t_busy_n, 5);
    chk("f0_addr_count", t_addr_q.size(), 4);
    for (int i = 0; i < 4 && i < t_addr_q.size(); i++)
      chk("f0_addr_step", {23'h0, t_addr_q[i]}, i);
    chk("f0_word", if_data, 32'h20010005);

    // error fetches: misaligned, straddling the top, first out-of-range word
    for (int i = 0; i < 3; i++) begin
      fa = (i == 0) ? 32'h2 : (i == 1) ? 32'h1FE : 32'h200;
      txn(1'b1, 1'b0, fa, 32'h0, 8'h0);
      chk("ferr_latency", t_rdy_at, 1);
      chk("ferr_mem_addr_nz", {31'h0, t_addr_nz}, 32'h0);
      chk("ferr_err", {31'h0, if_err}, 32'h1);
      chk("ferr_data", if_data, 32'h0);
    end

    // loader writes then fetch of the same word; out-of-range write is dropped
    txn(1'b0, 1'b1, 32'h0, 32'h100, 8'h8C);
    txn(1'b0, 1'b1, 32'h0, 32'h101, 8'h01);
    txn(1'b0, 1'b1, 32'h0, 32'h102, 8'h00);
    txn(1'b0, 1'b1, 32'h0, 32'h103, 8'h04);
    txn(1'b1, 1'b0, 32'h100, 32'h0, 8'h0);
    chk("ld_fetch_word", if_data, 32'h8C010004);
    txn(1'b0, 1'b1, 32'h0, 32'h200, 8'h55);

    // last in-range word
    txn(1'b1, 1'b0, 32'h1FC, 32'h0, 8'h0);
    chk("top_word_err", {31'h0, if_err}, 32'h0);

    // abort a fetch in its cnt=2 read cycle
    @(negedge CLK);
    if_req = 1'b1; if_addr = 32'h100;
    repeat (3) @(negedge CLK);
    chk("abort_addr", {23'h0, mem_addr}, 32'h102);
    Reset = 1'b0;
    @(negedge CLK);
    if_req = 1'b0;
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_data", if_data, 32'h0);
    chk("abort_ready", {31'h0, if_ready}, 32'h0);
    Reset = 1'b1; last_ld = 1'b1;
    n = 0;
    repeat (8) begin @(negedge CLK); if (if_ready) n++; end
    chk("abort_no_ready", n, 0);
    txn(1'b1, 1'b0, 32'h100, 32'h0, 8'h0);
    chk("post_abort_word", if_data, 32'h8C010004);

    // randomized mix of fetches, loads and contended pairs
    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 2);
      r = $urandom_range(0, 9);
      fa = (r < 7) ? 32'($urandom_range(0, 15)) * 4 :
           (r == 7) ? (32'($urandom_range(0, 127)) * 4 + 32'($urandom_range(1, 3))) :
           (r == 8) ? 32'h1FC : $urandom;
      la = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 63));
      txn(kind != 1, kind != 0, fa, la, 8'($urandom));
    end

    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin @(negedge CLK); cyc++; end
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
